// File: rtl/module_keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, active-low row sense,
// press/release debounce, ghost rejection, auto-repeat and a key FIFO.
//
// Ports:
//   clk, n_reset           clock, asynchronous active-low reset
//   filas_raw [NUM_ROWS]   raw row pins, low = key closed
//   columnas  [NUM_COLS]   one-hot column drive
//   key_code  [CW]         FIFO head, col_idx*NUM_ROWS + row_idx
//   key_valid              FIFO non-empty
//   key_ready              pop head when key_valid && key_ready
//   key_held               a debounced key is pressed
//   overflow               sticky, a push was dropped on a full FIFO
//   clr_ovf                synchronous clear of overflow
module module_keypad_scanner #(
    parameter int NUM_COLS     = 4,
    parameter int NUM_ROWS     = 4,
    parameter int SCAN_DIV     = 65536,
    parameter int DEBOUNCE     = 1023,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 8192,
    parameter int FIFO_DEPTH   = 4,
    localparam int CW = $clog2(NUM_COLS * NUM_ROWS)
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [NUM_ROWS-1:0] filas_raw,
    output logic [NUM_COLS-1:0] columnas,
    output logic [CW-1:0]       key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held,
    output logic                overflow,
    input  logic                clr_ovf
);

    localparam int CCW  = $clog2(NUM_COLS);
    localparam int RCW  = $clog2(NUM_ROWS);
    localparam int DW   = $clog2(SCAN_DIV);
    localparam int BW   = $clog2(DEBOUNCE + 1);
    localparam int PW   = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD,
        RELEASE
    } state_t;

    state_t            state, state_n;
    logic [NUM_ROWS-1:0] sync1, rows_s;
    logic [NUM_ROWS-1:0] pat, pat_n;
    logic [CCW-1:0]    col_idx, col_n, col_inc;
    logic [RCW-1:0]    row_idx, row_n, enc;
    logic [DW-1:0]     dwell, dwell_n;
    logic [BW-1:0]     deb, deb_n, deb_inc;
    logic [PW-1:0]     rep, rep_n, rep_inc;
    logic              held_n;
    logic              push;
    logic              single_low;
    logic [CW-1:0]     code;

    logic [CW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]   count;
    logic              full, pop, wr_en;

    assign single_low = $onehot(~rows_s);
    assign columnas   = {{(NUM_COLS-1){1'b0}}, 1'b1} << col_idx;
    assign col_inc    = (col_idx == CCW'(NUM_COLS - 1)) ? '0
                                                        : col_idx + 1'b1;
    assign deb_inc    = deb + 1'b1;
    assign rep_inc    = rep + 1'b1;
    assign code       = CW'(int'(col_idx) * NUM_ROWS + int'(row_idx));

    always_comb begin
        enc = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows_s[i]) enc = RCW'(i);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1 <= '1;
            rows_s <= '1;
        end else begin
            sync1 <= filas_raw;
            rows_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= SCAN;
            col_idx  <= '0;
            row_idx  <= '0;
            pat      <= '1;
            dwell    <= '0;
            deb      <= '0;
            rep      <= '0;
            key_held <= 1'b0;
        end else begin
            state    <= state_n;
            col_idx  <= col_n;
            row_idx  <= row_n;
            pat      <= pat_n;
            dwell    <= dwell_n;
            deb      <= deb_n;
            rep      <= rep_n;
            key_held <= held_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col_idx;
        row_n   = row_idx;
        pat_n   = pat;
        dwell_n = dwell;
        deb_n   = deb;
        rep_n   = rep;
        held_n  = key_held;
        push    = 1'b0;
        unique case (state)
            SCAN: begin
                if (dwell == DW'(SCAN_DIV - 1)) begin
                    dwell_n = '0;
                    if (single_low) begin
                        row_n   = enc;
                        pat_n   = rows_s;
                        deb_n   = '0;
                        state_n = CONFIRM;
                    end else begin
                        col_n = col_inc;
                    end
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            CONFIRM: begin
                if (rows_s == pat) begin
                    if (deb_inc == BW'(DEBOUNCE)) begin
                        push    = 1'b1;
                        held_n  = 1'b1;
                        rep_n   = '0;
                        deb_n   = '0;
                        state_n = HELD;
                    end else begin
                        deb_n = deb_inc;
                    end
                end else begin
                    deb_n   = '0;
                    col_n   = col_inc;
                    state_n = SCAN;
                end
            end
            HELD: begin
                if (rows_s[row_idx]) begin
                    deb_n   = '0;
                    state_n = RELEASE;
                end else if (REPEAT_DELAY > 0) begin
                    // After the first repeat rep parks at REPEAT_DELAY
                    // and re-arms every REPEAT_RATE cycles from there.
                    rep_n = rep_inc;
                    if (rep_inc == PW'(REPEAT_DELAY)) begin
                        push = 1'b1;
                    end else if (rep_inc ==
                                 PW'(REPEAT_DELAY + REPEAT_RATE)) begin
                        push  = 1'b1;
                        rep_n = PW'(REPEAT_DELAY);
                    end
                end
            end
            RELEASE: begin
                if (rows_s[row_idx]) begin
                    if (deb_inc == BW'(DEBOUNCE)) begin
                        held_n  = 1'b0;
                        deb_n   = '0;
                        col_n   = col_inc;
                        state_n = SCAN;
                    end else begin
                        deb_n = deb_inc;
                    end
                end else begin
                    // Bounce back to HELD keeps rep running.
                    state_n = HELD;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    assign key_valid = (count != '0);
    assign full      = (count == CNTW'(FIFO_DEPTH));
    assign pop       = key_valid && key_ready;
    assign wr_en     = push && (!full || pop);
    assign key_code  = key_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= code;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Directed bench for module_keypad_scanner with a keypad matrix model.
// Instance a has repeat disabled, instance b repeats (40/20).
module tb_module_keypad_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_reset, clr_ovf, ready_a, ready_b;
    logic [3:0] filas_a, filas_b, col_a, col_b;
    logic [3:0] code_a, code_b;
    logic       valid_a, valid_b, held_a, held_b, ovf_a, ovf_b;
    logic [15:0] pressed;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int qa[$];
    int qb_cyc[$];
    int qb_code[$];

    module_keypad_scanner #(
        .NUM_COLS(4), .NUM_ROWS(4), .SCAN_DIV(4), .DEBOUNCE(8),
        .REPEAT_DELAY(0), .REPEAT_RATE(20), .FIFO_DEPTH(2)
    ) u_a (
        .clk(clk), .n_reset(n_reset), .filas_raw(filas_a),
        .columnas(col_a), .key_code(code_a), .key_valid(valid_a),
        .key_ready(ready_a), .key_held(held_a), .overflow(ovf_a),
        .clr_ovf(clr_ovf)
    );

    module_keypad_scanner #(
        .NUM_COLS(4), .NUM_ROWS(4), .SCAN_DIV(4), .DEBOUNCE(8),
        .REPEAT_DELAY(40), .REPEAT_RATE(20), .FIFO_DEPTH(2)
    ) u_b (
        .clk(clk), .n_reset(n_reset), .filas_raw(filas_b),
        .columnas(col_b), .key_code(code_b), .key_valid(valid_b),
        .key_ready(ready_b), .key_held(held_b), .overflow(ovf_b),
        .clr_ovf(clr_ovf)
    );

    // Key index c*4+r closes column c onto row r.
    always_comb begin
        filas_a = '1;
        filas_b = '1;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4+r]) begin
                    if (col_a[c]) filas_a[r] = 1'b0;
                    if (col_b[c]) filas_b[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid_a && ready_a) qa.push_back(int'(code_a));
        if (valid_b && ready_b) begin
            qb_cyc.push_back(cyc);
            qb_code.push_back(int'(code_b));
        end
    end

    task automatic wait_held(input logic lvl, input int bound,
                             input string nm, output int n);
        n = 0;
        while (held_a !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (held_a !== lvl) begin
            n_err++;
            $display("FAIL %s: key_held=%b want %b", nm, held_a, lvl);
        end
    endtask

    task automatic wait_valid_a(input int bound, input string nm);
        int n;
        n = 0;
        while (valid_a !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (valid_a !== 1'b1) begin
            n_err++;
            $display("FAIL %s: key_valid=%b want 1", nm, valid_a);
        end
    endtask

    task automatic test_reset();
        int n;
        pressed = '0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        clr_ovf = 1'b0;
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (col_a !== 4'b0001 || valid_a !== 1'b0 || code_a !== 4'd0 ||
            held_a !== 1'b0 || ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset: col=%b v=%b code=%0d h=%b o=%b want 0001 0 0 0 0",
                     col_a, valid_a, code_a, held_a, ovf_a);
        end
        n_reset = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (col_a !== 4'b0001) break;
        end
        n_vec++;
        if (n != 4 || col_a !== 4'b0010) begin
            n_err++;
            $display("FAIL dwell: col=%b after %0d cycles want 0010 after 4",
                     col_a, n);
        end
    endtask

    task automatic test_single_key();
        int n;
        qa.delete();
        pressed[9] = 1'b1;
        wait_valid_a(200, "t1_valid");
        n_vec++;
        if (code_a !== 4'd9 || held_a !== 1'b1) begin
            n_err++;
            $display("FAIL t1_code: code=%0d held=%b want 9 1", code_a, held_a);
        end
        repeat (30) @(negedge clk);
        n_vec++;
        if (qa.size() != 1 || held_a !== 1'b1) begin
            n_err++;
            $display("FAIL t1_once: pops=%0d held=%b want 1 1", qa.size(), held_a);
        end
        pressed[9] = 1'b0;
        wait_held(1'b0, 100, "t1_release", n);
        n_vec++;
        if (n < 8) begin
            n_err++;
            $display("FAIL t1_rel_time: %0d cycles want >=8", n);
        end
        repeat (10) @(negedge clk);
        n_vec++;
        if (qa.size() != 1) begin
            n_err++;
            $display("FAIL t1_total: pops=%0d want 1", qa.size());
        end
    endtask

    task automatic test_bounce();
        int n;
        qa.delete();
        for (int i = 0; i < 10; i++) begin
            pressed[9] = ~pressed[9];
            repeat (3) @(negedge clk);
        end
        n_vec++;
        if (qa.size() != 0 || valid_a !== 1'b0 || held_a !== 1'b0) begin
            n_err++;
            $display("FAIL t2_bounce: pops=%0d v=%b h=%b want 0 0 0",
                     qa.size(), valid_a, held_a);
        end
        pressed[9] = 1'b1;
        wait_valid_a(200, "t2_valid");
        n_vec++;
        if (code_a !== 4'd9) begin
            n_err++;
            $display("FAIL t2_code: code=%0d want 9", code_a);
        end
        repeat (20) @(negedge clk);
        pressed[9] = 1'b0;
        wait_held(1'b0, 100, "t2_release", n);
        repeat (5) @(negedge clk);
        n_vec++;
        if (qa.size() != 1) begin
            n_err++;
            $display("FAIL t2_once: pops=%0d want 1", qa.size());
        end
    endtask

    task automatic test_ghost();
        logic [3:0] prev, expc;
        int changes;
        bit any;
        qa.delete();
        pressed[4] = 1'b1;
        pressed[6] = 1'b1;
        prev = col_a;
        changes = 0;
        any = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (valid_a !== 1'b0 || held_a !== 1'b0) any = 1'b1;
            if (col_a !== prev) begin
                expc = {prev[2:0], prev[3]};
                n_vec++;
                if (col_a !== expc) begin
                    n_err++;
                    $display("FAIL t3_rotate: col=%b want %b", col_a, expc);
                end
                prev = col_a;
                changes++;
            end
        end
        n_vec++;
        if (changes < 12 || any || qa.size() != 0) begin
            n_err++;
            $display("FAIL t3_ghost: changes=%0d active=%b pops=%0d want >=12 0 0",
                     changes, any, qa.size());
        end
        pressed = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_repeat();
        int n;
        int d, e;
        qb_cyc.delete();
        qb_code.delete();
        pressed[0] = 1'b1;
        n = 0;
        while (valid_b !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (110) @(negedge clk);
        pressed[0] = 1'b0;
        repeat (60) @(negedge clk);
        n_vec++;
        if (qb_cyc.size() != 5) begin
            n_err++;
            $display("FAIL t4_count: pushes=%0d want 5", qb_cyc.size());
        end
        if (qb_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) begin
                d = qb_cyc[i] - qb_cyc[i-1];
                e = (i == 1) ? 40 : 20;
                n_vec++;
                if (d != e || qb_code[i] != 0) begin
                    n_err++;
                    $display("FAIL t4_gap%0d: gap=%0d code=%0d want %0d 0",
                             i, d, qb_code[i], e);
                end
            end
        end
    endtask

    task automatic press_release(input int k, input string nm);
        int n;
        pressed[k] = 1'b1;
        wait_held(1'b1, 200, nm, n);
        pressed[k] = 1'b0;
        wait_held(1'b0, 100, nm, n);
    endtask

    task automatic test_overflow();
        ready_a = 1'b0;
        press_release(3, "t5_k3");
        press_release(12, "t5_k12");
        press_release(5, "t5_k5");
        n_vec++;
        if (ovf_a !== 1'b1 || valid_a !== 1'b1 || code_a !== 4'd3) begin
            n_err++;
            $display("FAIL t5_full: ovf=%b v=%b code=%0d want 1 1 3",
                     ovf_a, valid_a, code_a);
        end
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        n_vec++;
        if (valid_a !== 1'b1 || code_a !== 4'd12 || ovf_a !== 1'b1) begin
            n_err++;
            $display("FAIL t5_second: v=%b code=%0d ovf=%b want 1 12 1",
                     valid_a, code_a, ovf_a);
        end
        ready_a = 1'b1;
        repeat (4) @(negedge clk);
        ready_a = 1'b0;
        n_vec++;
        if (valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL t5_empty: key_valid=%b want 0", valid_a);
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        n_vec++;
        if (ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL t5_clear: overflow=%b want 0", ovf_a);
        end
    endtask

    task automatic test_clear_priority();
        ready_a = 1'b0;
        press_release(3, "t5b_k3");
        press_release(12, "t5b_k12");
        clr_ovf = 1'b1;
        press_release(5, "t5b_k5");
        clr_ovf = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ovf_a !== 1'b0 || code_a !== 4'd3) begin
            n_err++;
            $display("FAIL t5b_clrwin: ovf=%b code=%0d want 0 3", ovf_a, code_a);
        end
    endtask

    task automatic test_reset_held();
        int n;
        pressed[9] = 1'b1;
        wait_held(1'b1, 200, "t6_press", n);
        repeat (5) @(negedge clk);
        n_vec++;
        if (ovf_a !== 1'b1 || valid_a !== 1'b1 || col_a !== 4'b0100) begin
            n_err++;
            $display("FAIL t6_pre: ovf=%b v=%b col=%b want 1 1 0100",
                     ovf_a, valid_a, col_a);
        end
        n_reset = 1'b0;
        #1;
        n_vec++;
        if (col_a !== 4'b0001 || valid_a !== 1'b0 || held_a !== 1'b0 ||
            ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL t6_reset: col=%b v=%b h=%b o=%b want 0001 0 0 0",
                     col_a, valid_a, held_a, ovf_a);
        end
        pressed = '0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        n = 0;
        while (col_a !== 4'b0010 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (col_a !== 4'b0010 || valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL t6_resume: col=%b v=%b want 0010 0", col_a, valid_a);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_ghost();
        test_repeat();
        test_overflow();
        test_clear_priority();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
